// File: rtl/ppu_tile_sched.sv
// Tile scheduler for the post-processing unit: waits for accumulator tiles, streams
// each tile's 16 rows to the PPU at a fixed 17-cycle cadence, and replays all tiles for two-pass modes.
module ppu_tile_sched #(
    parameter int         NUM_TILES     = 16,
    parameter int         LANES         = 16,
    parameter int         ACC_W         = 24,
    parameter int         ROWS          = 16,
    parameter logic [1:0] MODE_INT4_VSQ = 2'b00
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst_n,
    input  logic                                        i_cfg_valid,
    output logic                                        o_cfg_ready,
    input  logic [1:0]                                  i_cfg_mode,
    input  logic                                        i_cfg_relu_en,
    input  logic [$clog2(NUM_TILES+1)-1:0]              i_tiles_written,
    output logic                                        o_acc_rd_en,
    output logic [$clog2(NUM_TILES)+$clog2(ROWS)-1:0]   o_acc_rd_addr,
    input  logic [LANES*ACC_W-1:0]                      i_acc_rd_data,
    output logic                                        o_ppu_start,
    output logic [LANES*ACC_W-1:0]                      o_ppu_acc_data,
    output logic [1:0]                                  o_ppu_mode,
    output logic                                        o_ppu_relu_en,
    output logic                                        o_buf_release,
    output logic                                        o_busy,
    output logic                                        o_done
);

    localparam int TILE_W = $clog2(NUM_TILES);
    localparam int CNT_W  = $clog2(NUM_TILES + 1);
    localparam int ROW_W  = $clog2(ROWS);
    localparam int ADDR_W = TILE_W + ROW_W;

    localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state_r, state_s;
    logic [TILE_W-1:0] tile_r, tile_s;
    logic [ROW_W-1:0]  row_r, row_s;
    logic              pass_r, pass_s;
    logic              two_pass_r;
    logic [1:0]        mode_r;
    logic              relu_r;
    logic              cfg_ready_r, busy_r, done_r, release_r;
    logic              rd_en_r, start_r;
    logic [ADDR_W-1:0] addr_r;
    logic              accept_s;

    // The calc pass replays tiles already known to be resident, so it never stalls.
    function automatic logic tile_ready(input logic [TILE_W-1:0] t, input logic p,
                                        input logic [CNT_W-1:0] written);
        return p || (CNT_W'(t) < written);
    endfunction

    assign accept_s = (state_r == S_IDLE) && i_cfg_valid;

    // Next-state, tile, row and pass sequencing.
    always_comb begin
        state_s = state_r;
        tile_s  = tile_r;
        row_s   = row_r;
        pass_s  = pass_r;
        case (state_r)
            S_IDLE: begin
                if (i_cfg_valid) begin
                    state_s = S_WAIT;
                    tile_s  = {TILE_W{1'b0}};
                    row_s   = {ROW_W{1'b0}};
                    pass_s  = 1'b0;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (tile_ready(tile_r, pass_r, i_tiles_written)) begin
                    state_s = S_STREAM;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_STREAM: begin
                row_s = row_r + {{(ROW_W-1){1'b0}}, 1'b1};
                if (row_r == LAST_ROW) begin
                    state_s = S_GAP;
                end else begin
                    state_s = S_STREAM;
                end
            end
            S_GAP: begin
                // The gap cycle lets the PPU return to idle; the next tile may start right after it.
                if (tile_r != LAST_TILE) begin
                    tile_s = tile_r + {{(TILE_W-1){1'b0}}, 1'b1};
                    if (tile_ready(tile_s, pass_r, i_tiles_written)) begin
                        state_s = S_STREAM;
                    end else begin
                        state_s = S_WAIT;
                    end
                end else if (two_pass_r && !pass_r) begin
                    tile_s  = {TILE_W{1'b0}};
                    pass_s  = 1'b1;
                    state_s = S_STREAM;
                end else begin
                    state_s = S_DONE;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
                tile_s  = {TILE_W{1'b0}};
                row_s   = {ROW_W{1'b0}};
                pass_s  = 1'b0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= S_IDLE;
            tile_r  <= {TILE_W{1'b0}};
            row_r   <= {ROW_W{1'b0}};
            pass_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            tile_r  <= tile_s;
            row_r   <= row_s;
            pass_r  <= pass_s;
        end
    end

    // Job configuration latched on accept and held until the next accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_r     <= 2'b00;
            relu_r     <= 1'b0;
            two_pass_r <= 1'b0;
        end else if (accept_s) begin
            mode_r     <= i_cfg_mode;
            relu_r     <= i_cfg_relu_en;
            two_pass_r <= (i_cfg_mode != MODE_INT4_VSQ);
        end else begin
            mode_r     <= mode_r;
            relu_r     <= relu_r;
            two_pass_r <= two_pass_r;
        end
    end

    // Registered outputs decoded from the next state so they line up with the state they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cfg_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            release_r   <= 1'b0;
            rd_en_r     <= 1'b0;
            start_r     <= 1'b0;
            addr_r      <= {ADDR_W{1'b0}};
        end else begin
            cfg_ready_r <= (state_s == S_IDLE);
            busy_r      <= (state_s == S_WAIT) || (state_s == S_STREAM) || (state_s == S_GAP);
            done_r      <= (state_s == S_DONE);
            release_r   <= (state_s == S_DONE);
            rd_en_r     <= (state_s == S_STREAM);
            start_r     <= (state_s == S_STREAM) && (state_r != S_STREAM);
            addr_r      <= (state_s == S_STREAM) ? {tile_s, row_s} : {ADDR_W{1'b0}};
        end
    end

    assign o_cfg_ready    = cfg_ready_r;
    assign o_busy         = busy_r;
    assign o_done         = done_r;
    assign o_buf_release  = release_r;
    assign o_acc_rd_en    = rd_en_r;
    assign o_acc_rd_addr  = addr_r;
    assign o_ppu_start    = start_r;
    assign o_ppu_mode     = mode_r;
    assign o_ppu_relu_en  = relu_r;
    assign o_ppu_acc_data = i_acc_rd_data;

endmodule

// File: tb/tb_ppu_tile_sched.sv
// Directed bench for ppu_tile_sched: a registered accumulator-buffer model returns
// a per-address pattern one cycle after each read.
module tb_ppu_tile_sched;

    localparam int         NT    = 16;
    localparam int         LANES = 16;
    localparam int         ACC_W = 24;
    localparam int         DW    = LANES * ACC_W;
    localparam logic [1:0] MODE_VSQ = 2'b00;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_mode;
    logic          cfg_relu;
    logic [4:0]    tw;
    logic          rd_en;
    logic [7:0]    rd_addr;
    logic [DW-1:0] rd_data;
    logic          ppu_start;
    logic [DW-1:0] ppu_data;
    logic [1:0]    ppu_mode;
    logic          ppu_relu;
    logic          buf_release;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int rel_cnt = 0;

    always #5 clk = ~clk;

    ppu_tile_sched dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_cfg_valid     (cfg_valid),
        .o_cfg_ready     (cfg_ready),
        .i_cfg_mode      (cfg_mode),
        .i_cfg_relu_en   (cfg_relu),
        .i_tiles_written (tw),
        .o_acc_rd_en     (rd_en),
        .o_acc_rd_addr   (rd_addr),
        .i_acc_rd_data   (rd_data),
        .o_ppu_start     (ppu_start),
        .o_ppu_acc_data  (ppu_data),
        .o_ppu_mode      (ppu_mode),
        .o_ppu_relu_en   (ppu_relu),
        .o_buf_release   (buf_release),
        .o_busy          (busy),
        .o_done          (done)
    );

    function automatic logic [DW-1:0] pat(input logic [7:0] a);
        logic [DW-1:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++) v[l*ACC_W +: ACC_W] = {a, 8'(l), ~a};
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else        rd_data <= rd_en ? pat(rd_addr) : '0;
    end

    always @(negedge clk) begin
        if (done)        done_cnt <= done_cnt + 1;
        if (buf_release) rel_cnt  <= rel_cnt + 1;
    end

    task automatic test_reset();
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'b00; cfg_relu = 1'b0; tw = 5'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cfg_ready, busy, done, buf_release, ppu_start, rd_en, rd_addr, ppu_mode, ppu_relu} !== 17'h10000) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h",
                     {cfg_ready, busy, done, buf_release, ppu_start, rd_en, rd_addr, ppu_mode, ppu_relu}, 17'h10000);
        end
        checks++;
        if (ppu_data !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", ppu_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got ready=%b busy=%b exp ready=1 busy=0", cfg_ready, busy);
        end
    endtask

    // Full job with every tile resident: cycle-exact start cadence, address order, data alignment, done timing.
    task automatic test_full_job(input logic [1:0] mode, input logic relu, input int npass);
        int done0, rel0, reads, waited;
        logic [3:0] t, r;
        logic [14:0] got, exp;
        tw = 5'd16;
        done0 = done_cnt; rel0 = rel_cnt; reads = 0;
        cfg_valid = 1'b1; cfg_mode = mode; cfg_relu = relu;
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if ({busy, cfg_ready, ppu_mode, ppu_relu} !== {1'b1, 1'b0, mode, relu}) begin
            failures++;
            $display("FAIL job_accept got=%b exp=%b", {busy, cfg_ready, ppu_mode, ppu_relu}, {1'b1, 1'b0, mode, relu});
        end
        waited = 0;
        while (!ppu_start && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (ppu_start !== 1'b1) begin
            failures++;
            $display("FAIL job_first_start got=timeout exp=start within 8 cycles");
        end
        for (int i = 0; i < NT * npass; i++) begin
            t = 4'(i % NT);
            for (int k = 0; k < 17; k++) begin
                r = 4'(k);
                exp = {(k == 0), (k < 16), (k < 16) ? {t, r} : 8'h00, 1'b0, 1'b1, mode, relu};
                got = {ppu_start, rd_en, rd_addr, done, busy, ppu_mode, ppu_relu};
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL stream i=%0d k=%0d got=%h exp=%h", i, k, got, exp);
                end
                if (k > 0) begin
                    checks++;
                    if (ppu_data !== pat({t, 4'(k - 1)})) begin
                        failures++;
                        $display("FAIL row_data i=%0d row=%0d got=%h exp=%h", i, k - 1, ppu_data, pat({t, 4'(k - 1)}));
                    end
                end
                if (rd_en) reads++;
                @(negedge clk);
            end
        end
        checks++;
        if ({done, buf_release, busy, cfg_ready, rd_en, ppu_start} !== 6'b110000) begin
            failures++;
            $display("FAIL job_done got=%b exp=110000", {done, buf_release, busy, cfg_ready, rd_en, ppu_start});
        end
        checks++;
        if (reads != 256 * npass) begin
            failures++;
            $display("FAIL read_count got=%0d exp=%0d", reads, 256 * npass);
        end
        @(negedge clk);
        checks++;
        if ({cfg_ready, done, buf_release, done_cnt - done0, rel_cnt - rel0} !== {3'b100, 32'd1, 32'd1}) begin
            failures++;
            $display("FAIL job_after got ready=%b done=%b rel=%b ndone=%0d nrel=%0d exp 1 0 0 1 1",
                     cfg_ready, done, buf_release, done_cnt - done0, rel_cnt - rel0);
        end
    endtask

    task automatic test_starvation();
        int stray, t0reads, waited;
        tw = 5'd0;
        cfg_valid = 1'b1; cfg_mode = MODE_VSQ; cfg_relu = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b0;
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (rd_en || ppu_start) stray++;
        end
        checks++;
        if (stray != 0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL starve_idle got stray=%0d busy=%b exp stray=0 busy=1", stray, busy);
        end
        tw = 5'd1;
        @(negedge clk);
        checks++;
        if ({ppu_start, rd_en, rd_addr} !== {1'b1, 1'b1, 8'h00}) begin
            failures++;
            $display("FAIL starve_tile0_start got=%h exp=%h", {ppu_start, rd_en, rd_addr}, {1'b1, 1'b1, 8'h00});
        end
        t0reads = 1;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            if (rd_en && rd_addr[7:4] == 4'd0) t0reads++;
        end
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (rd_en || ppu_start) stray++;
        end
        checks++;
        if (t0reads != 16 || stray != 0) begin
            failures++;
            $display("FAIL starve_tile1_held got t0reads=%0d stray=%0d exp 16 0", t0reads, stray);
        end
        tw = 5'd2;
        @(negedge clk);
        checks++;
        if ({ppu_start, rd_en, rd_addr} !== {1'b1, 1'b1, 8'h10}) begin
            failures++;
            $display("FAIL starve_tile1_start got=%h exp=%h", {ppu_start, rd_en, rd_addr}, {1'b1, 1'b1, 8'h10});
        end
        tw = 5'd16;
        waited = 0;
        while (!done && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL starve_done got=timeout exp=done");
        end
        @(negedge clk);
    endtask

    task automatic test_cfg_while_busy();
        int nstart, waited;
        tw = 5'd16;
        cfg_valid = 1'b1; cfg_mode = 2'b01; cfg_relu = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        nstart = 0;
        repeat (50) begin
            @(negedge clk);
            if (ppu_start) nstart++;
        end
        cfg_valid = 1'b1; cfg_mode = 2'b00; cfg_relu = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ppu_start) nstart++;
            checks++;
            if ({ppu_mode, ppu_relu, cfg_ready, busy} !== 5'b01101) begin
                failures++;
                $display("FAIL busy_cfg_ignored got=%b exp=01101", {ppu_mode, ppu_relu, cfg_ready, busy});
            end
        end
        cfg_valid = 1'b0;
        waited = 0;
        while (!done && waited < 700) begin
            @(negedge clk);
            waited++;
            if (ppu_start) nstart++;
        end
        checks++;
        if (done !== 1'b1 || nstart != 32 || ppu_mode !== 2'b01) begin
            failures++;
            $display("FAIL busy_job_end got done=%b starts=%0d mode=%b exp 1 32 01", done, nstart, ppu_mode);
        end
        cfg_valid = 1'b1; cfg_mode = 2'b10; cfg_relu = 1'b0;
        @(negedge clk);
        checks++;
        if ({cfg_ready, busy, ppu_mode} !== 4'b1001) begin
            failures++;
            $display("FAIL after_done_ready got=%b exp=1001", {cfg_ready, busy, ppu_mode});
        end
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if ({cfg_ready, busy, ppu_mode, ppu_relu} !== 5'b01100) begin
            failures++;
            $display("FAIL after_done_accept got=%b exp=01100", {cfg_ready, busy, ppu_mode, ppu_relu});
        end
        waited = 0;
        while (!done && waited < 700) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL second_job_done got=timeout exp=done");
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_job();
        int nstart, waited, done0, rel0;
        tw = 5'd16;
        cfg_valid = 1'b1; cfg_mode = 2'b01; cfg_relu = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        nstart = 0; waited = 0;
        while (nstart < 6 && waited < 200) begin
            @(negedge clk);
            waited++;
            if (ppu_start) nstart++;
        end
        checks++;
        if (nstart != 6 || rd_addr !== 8'h50) begin
            failures++;
            $display("FAIL midrst_tile5 got starts=%0d addr=%h exp 6 50", nstart, rd_addr);
        end
        repeat (2) @(negedge clk);
        done0 = done_cnt; rel0 = rel_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cfg_ready, busy, done, buf_release, ppu_start, rd_en, rd_addr, ppu_mode, ppu_relu} !== 17'h10000
            || ppu_data !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got=%h exp=%h",
                     {cfg_ready, busy, done, buf_release, ppu_start, rd_en, rd_addr, ppu_mode, ppu_relu}, 17'h10000);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (done_cnt != done0 || rel_cnt != rel0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_no_pulse got ndone=%0d nrel=%0d ready=%b exp 0 0 1",
                     done_cnt - done0, rel_cnt - rel0, cfg_ready);
        end
        test_full_job(MODE_VSQ, 1'b0, 1);
    endtask

    initial begin
        test_reset();
        test_full_job(MODE_VSQ, 1'b1, 1);
        test_full_job(2'b11, 1'b0, 2);
        test_starvation();
        test_cfg_while_busy();
        test_reset_mid_job();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
